inst_fetch_queue: RTL
=====================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and request credit limit; power of 2, at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 redirect_valid  in  1  branch/jump redirect strobe.
REQ-006 redirect_pc  in  32  new fetch address, sampled when redirect_valid=1.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  request address, always equal to the fetch pointer fpc.
REQ-009 imem_gnt  in  1  request accepted; a request is taken only when imem_req=1 and imem_gnt=1 in the same cycle.
REQ-010 imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-011 imem_rdata  in  32  response instruction word.
REQ-012 id_valid  out  1  queue head valid toward decode.
REQ-013 id_instr  out  32  instruction at the queue head.
REQ-014 id_pc  out  32  address of id_instr.
REQ-015 id_ready  in  1  decode accepts the head; a pop occurs when id_valid=1 and id_ready=1.
REQ-016 fetch_err  out  1  present only with IFU_MISALIGN_CHECK_EN (see REQ-033).

Function
REQ-017 Internal state: fpc (next request address), rpc (address of next expected response), outstanding counter (0..DEPTH), count (0..DEPTH), FSM {FETCH, DRAIN}.
REQ-018 In FETCH, imem_req=1 iff count+outstanding < DEPTH; the queue never overflows.
REQ-019 On grant: fpc <= fpc+4 with wrap modulo 2^32; outstanding increments.
REQ-020 On rvalid in FETCH: push {imem_rdata, rpc}; rpc <= rpc+4; outstanding decrements.
REQ-021 Same-cycle grant and rvalid leave outstanding unchanged; same-cycle push and pop leave count unchanged, including when the queue is full.
REQ-022 id_valid = (count != 0); zero-latency head output; pushed entry visible the following cycle.
REQ-023 Redirect in any state: queue flushed (count <= 0); fpc <= redirect_pc; rpc <= redirect_pc; next state is DRAIN if the post-update outstanding > 0, else FETCH.
REQ-024 The flush takes priority over a same-cycle pop and push; a same-cycle rvalid is discarded; a same-cycle grant is counted as outstanding and later discarded.
REQ-025 DRAIN: imem_req=0; every rvalid is discarded and decrements outstanding; when the last discard occurs, the next state is FETCH.
REQ-026 A redirect in DRAIN reloads fpc and rpc and the block stays in DRAIN.
REQ-027 id_valid=0 in the cycle after any redirect.
REQ-028 Full queue with id_ready=0 holds the head stable and imem_req=0 until a pop frees credit.

Reset
REQ-029 Reset values: fpc=rpc=RESET_PC, count=0, outstanding=0, FSM=FETCH, id_valid=0, imem_req=0 while reset is asserted.
REQ-030 Reset mid-transaction abandons all outstanding requests; responses arriving after reset deassertion are the memory's responsibility and the block does not track them.
REQ-031 The first request is issued in the first cycle after reset deassertion, with imem_addr=RESET_PC.

Configuration
REQ-032 Macro IFU_MISALIGN_CHECK_EN.
REQ-033 With the macro defined: port fetch_err exists.
- A redirect_pc with [1:0]!=0 sets fetch_err=1, flushes as in REQ-023, and blocks requests until the next redirect with an aligned address, which clears fetch_err.
- fetch_err resets to 0.
REQ-034 Without the macro: no fetch_err port; redirect_pc[1:0] is forced to 2'b00.

Verification
REQ-035 Reset release, gnt=1 every cycle, rvalid 1 cycle later, id_ready=1 -> imem_addr 0,4,8,...; id_pc 0,4,8 with matching id_instr in order.
REQ-036 id_ready=0, DEPTH=4 -> exactly 4 grants, then imem_req=0, count=4; one pop -> exactly one new request.
REQ-037 Redirect to 32'h100 with 2 outstanding -> DRAIN, 2 responses dropped, then imem_addr=32'h100 and first id_pc=32'h100.
REQ-038 Redirect coincident with grant and rvalid -> both dropped; no stale entry reaches decode.
REQ-039 fpc=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
REQ-040 With macro: redirect_pc=32'h102 -> fetch_err=1, imem_req=0; redirect to 32'h200 -> fetch_err=0, fetching resumes.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch unit with a DEPTH-entry instruction queue. Issues
//   sequential fetch requests to instruction memory under a credit limit
//   (queued entries + requests in flight never exceed DEPTH), queues the
//   in-order responses together with their addresses, and presents the queue
//   head to decode. A redirect flushes the queue, reloads the fetch address
//   and drains (discards) every response still in flight before fetching
//   from the new address.
//
//   Optional feature (macro IFU_MISALIGN_CHECK_EN): a redirect to an address
//   with bits [1:0] != 0 raises fetch_err and blocks requests until a
//   redirect to an aligned address. Without the macro the port is absent and
//   redirect_pc[1:0] is forced to zero.
//
// Parameters
//   DEPTH     queue entries and request credit limit (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   redirect_valid/pc  branch/jump redirect strobe and target
//   imem_req/addr      memory request and its address (the fetch pointer)
//   imem_gnt           request accepted (with imem_req)
//   imem_rvalid/rdata  in-order response strobe and instruction word
//   id_valid/instr/pc  queue head toward decode
//   id_ready           decode accepts the head
//   fetch_err          misaligned redirect flag (macro builds only)
// ----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        fetch_err
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fpc_q, fpc_d;
    logic [31:0]        rpc_q, rpc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    logic [CNT_W:0]     used;
    logic               grant, rsp, push, pop, blocked;
    logic [31:0]        redir_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic err_q, err_d;

    assign redir_pc  = redirect_pc;
    assign blocked   = err_q;
    assign fetch_err = err_q;
    assign err_d     = redirect_valid ? (redirect_pc[1:0] != 2'b00) : err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign redir_pc = {redirect_pc[31:2], 2'b00};
    assign blocked  = 1'b0;
`endif

    // Credit counts both queued entries and requests still in flight, so a
    // response always finds a free slot.
    assign used      = {1'b0, count_q} + {1'b0, out_q};
    assign imem_addr = fpc_q;
    assign id_valid  = (count_q != '0);
    assign id_instr  = instr_mem[head_q];
    assign id_pc     = pc_mem[head_q];

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        rpc_d    = rpc_q;
        out_d    = out_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        imem_req = 1'b0;

        if (state_q == StFetch && !blocked && !reset && (used < DEPTH_SUM)) begin
            imem_req = 1'b1;
        end

        grant = imem_req & imem_gnt;
        // A response with nothing in flight (e.g. abandoned across reset) is ignored.
        rsp   = imem_rvalid & (out_q != '0);
        push  = rsp & (state_q == StFetch) & ~redirect_valid;
        pop   = id_valid & id_ready & ~redirect_valid;

        if (grant) begin
            fpc_d = fpc_q + 32'd4;
        end

        unique case ({grant, rsp})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        if (push) begin
            rpc_d  = rpc_q + 32'd4;
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (state_q == StDrain && out_d == '0) begin
            state_d = StFetch;
        end

        // Flush wins over everything; a same-cycle grant stays counted in
        // out_d and is discarded later in drain.
        if (redirect_valid) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            fpc_d   = redir_pc;
            rpc_d   = redir_pc;
            state_d = (out_d != '0) ? StDrain : StFetch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            out_q   <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            out_q   <= out_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= rpc_q;
        end
    end

endmodule
